// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, NZCV flag positions and the
// operand-prep carry-in rule used by the adder pipeline.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_ADC = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_SBB = 2'b11;

  // Bit positions when the flags are packed as an NZCV nibble.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Subtraction is a + ~b + 1, so a borrow-in becomes an inverted carry-in.
  function automatic logic carry_in0(input logic [1:0] op, input logic cin);
    case (op)
      OP_ADD:  return 1'b0;
      OP_ADC:  return cin;
      OP_SUB:  return 1'b1;
      default: return ~cin;
    endcase
  endfunction

endpackage

// File: rtl/cla_blk.sv
// One BLK-bit carry-lookahead group: flat per-bit carries from cin plus
// group generate/propagate for the second lookahead level.
module cla_blk #(
  parameter int BLK = 8
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           cin,
  output logic [BLK-1:0] sum,
  output logic           G,
  output logic           P,
  output logic           c_msb_in
);

  logic [BLK-1:0] gen;
  logic [BLK-1:0] prop;
  logic [BLK-1:0] c;
  logic           term;

  assign gen  = a & b;
  assign prop = a ^ b;

  // Each carry is a sum of products over gen/prop/cin, so the loops unroll
  // into two-level logic rather than a bit-serial ripple.
  always_comb begin
    c    = '0;
    G    = 1'b0;
    term = 1'b0;
    for (int i = 0; i < BLK; i++) begin
      term = cin;
      for (int k = 0; k < i; k++) term = term & prop[k];
      c[i] = term;
      for (int j = 0; j < i; j++) begin
        term = gen[j];
        for (int k = j + 1; k < i; k++) term = term & prop[k];
        c[i] = c[i] | term;
      end
    end
    for (int j = 0; j < BLK; j++) begin
      term = gen[j];
      for (int k = j + 1; k < BLK; k++) term = term & prop[k];
      G = G | term;
    end
  end

  assign sum      = prop ^ c;
  assign P        = &prop;
  assign c_msb_in = c[BLK-1];

endmodule

// File: rtl/add_pipe_cla.sv
// Pipelined two-level CLA adder/subtractor with ADC/SUB/SBB, NZCV flags and
// an elastic valid/ready pipeline; GRP groups are resolved per stage.
module add_pipe_cla
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BLK   = 8,
  parameter int GRP   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_c,
  output logic             out_v,
  output logic             out_z,
  output logic             out_n
);

  localparam int NBLK = WIDTH / BLK;
  localparam int LAT  = NBLK / GRP;
  localparam int SW   = BLK * GRP;

  if ((WIDTH % (BLK * GRP)) != 0) begin : g_bad_cfg
    $error("add_pipe_cla: WIDTH must be a multiple of BLK*GRP");
  end

  // Stage k inputs: index 0 is the prepared operand beat, index k>0 is the
  // register bank of stage k-1 (operands, partial sum, carry between stages).
  logic [WIDTH-1:0] st_a   [LAT];
  logic [WIDTH-1:0] st_b   [LAT];
  logic [WIDTH-1:0] st_sum [LAT];
  logic             st_c   [LAT];
  logic             st_sub [LAT];
  logic             st_v   [LAT];

  logic [WIDTH-1:0] a_reg   [LAT];
  logic [WIDTH-1:0] b_reg   [LAT];
  logic [WIDTH-1:0] sum_reg [LAT];
  logic             c_reg   [LAT];
  logic             sub_reg [LAT];
  logic             v_reg   [LAT];

  logic [WIDTH-1:0] blk_sum;
  logic             grp_cmsb [NBLK];

  for (genvar gi = 0; gi < NBLK; gi++) begin : g_blk
    localparam int STG = gi / GRP;
    logic cin;
    logic cout;
    logic g;
    logic p;

    // The first group of a stage starts from the carry registered by the
    // previous stage; the rest use group-level lookahead within the stage.
    if ((gi % GRP) == 0) begin : g_head
      assign cin = st_c[STG];
    end else begin : g_chain
      assign cin = g_blk[gi-1].cout;
    end

    cla_blk #(.BLK(BLK)) u_cla (
      .a        (st_a[STG][gi*BLK +: BLK]),
      .b        (st_b[STG][gi*BLK +: BLK]),
      .cin      (cin),
      .sum      (blk_sum[gi*BLK +: BLK]),
      .G        (g),
      .P        (p),
      .c_msb_in (grp_cmsb[gi])
    );

    assign cout = g | (p & cin);
  end

  for (genvar gi = 0; gi < LAT; gi++) begin : g_stage
    localparam int LO = gi * SW;
    logic             adv;
    logic             cout;
    logic [WIDTH-1:0] sum_new;

    if (gi == 0) begin : g_src
      assign st_a[gi]   = in_a;
      assign st_b[gi]   = in_op[1] ? ~in_b : in_b;
      assign st_c[gi]   = carry_in0(in_op, in_cin);
      assign st_sum[gi] = '0;
      assign st_sub[gi] = in_op[1];
      assign st_v[gi]   = in_valid;
    end else begin : g_fwd
      assign st_a[gi]   = a_reg[gi-1];
      assign st_b[gi]   = b_reg[gi-1];
      assign st_c[gi]   = c_reg[gi-1];
      assign st_sum[gi] = sum_reg[gi-1];
      assign st_sub[gi] = sub_reg[gi-1];
      assign st_v[gi]   = v_reg[gi-1];
    end

    assign cout = g_blk[gi*GRP + GRP - 1].cout;

    always_comb begin
      sum_new          = st_sum[gi];
      sum_new[LO +: SW] = blk_sum[LO +: SW];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_reg[gi]   <= 1'b0;
        a_reg[gi]   <= '0;
        b_reg[gi]   <= '0;
        sum_reg[gi] <= '0;
        c_reg[gi]   <= 1'b0;
        sub_reg[gi] <= 1'b0;
      end else if (adv) begin
        v_reg[gi] <= st_v[gi];
        if (st_v[gi]) begin
          a_reg[gi]   <= st_a[gi];
          b_reg[gi]   <= st_b[gi];
          sum_reg[gi] <= sum_new;
          c_reg[gi]   <= cout;
          sub_reg[gi] <= st_sub[gi];
        end
      end
    end

    if (gi == LAT - 1) begin : g_last
      assign adv = ~v_reg[gi] | out_ready;

      // Borrow is reported as the inverted carry for SUB/SBB.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out_c <= 1'b0;
          out_v <= 1'b0;
          out_z <= 1'b0;
          out_n <= 1'b0;
        end else if (adv && st_v[gi]) begin
          out_c <= cout ^ st_sub[gi];
          out_v <= grp_cmsb[NBLK-1] ^ cout;
          out_z <= (sum_new == '0);
          out_n <= sum_new[WIDTH-1];
        end
      end
    end else begin : g_mid
      assign adv = ~v_reg[gi] | g_stage[gi+1].adv;
    end
  end

  assign in_ready  = g_stage[0].adv;
  assign out_valid = v_reg[LAT-1];
  assign out_sum   = sum_reg[LAT-1];

endmodule

// File: tb/tb_add_pipe_cla.sv
// Bench for add_pipe_cla: three configurations (32/8/2, 16/4/1, 64/8/4)
// checked against a plain-arithmetic reference model.
module tb_add_pipe_cla;

  logic        clk;
  logic        rst;
  logic [2:0]  iv;
  logic [2:0]  ir;
  logic [2:0]  ov;
  logic [2:0]  oc;
  logic [2:0]  ovf;
  logic [2:0]  oz;
  logic [2:0]  on;
  logic [1:0]  op;
  logic [63:0] a;
  logic [63:0] b;
  logic        cin;
  logic        ordy;
  logic [31:0] s32;
  logic [15:0] s16;
  logic [63:0] s64;
  logic [67:0] obs [3];

  int checks;
  int errors;

  int w_of   [3] = '{32, 16, 64};
  int lat_of [3] = '{2, 4, 2};

  add_pipe_cla #(.WIDTH(32), .BLK(8), .GRP(2)) u_d32 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_op(op),
    .in_a(a[31:0]), .in_b(b[31:0]), .in_cin(cin), .out_valid(ov[0]),
    .out_ready(ordy), .out_sum(s32), .out_c(oc[0]), .out_v(ovf[0]),
    .out_z(oz[0]), .out_n(on[0])
  );

  add_pipe_cla #(.WIDTH(16), .BLK(4), .GRP(1)) u_d16 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_op(op),
    .in_a(a[15:0]), .in_b(b[15:0]), .in_cin(cin), .out_valid(ov[1]),
    .out_ready(ordy), .out_sum(s16), .out_c(oc[1]), .out_v(ovf[1]),
    .out_z(oz[1]), .out_n(on[1])
  );

  add_pipe_cla #(.WIDTH(64), .BLK(8), .GRP(4)) u_d64 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_op(op),
    .in_a(a), .in_b(b), .in_cin(cin), .out_valid(ov[2]),
    .out_ready(ordy), .out_sum(s64), .out_c(oc[2]), .out_v(ovf[2]),
    .out_z(oz[2]), .out_n(on[2])
  );

  assign obs[0] = {32'd0, s32, oc[0], ovf[0], oz[0], on[0]};
  assign obs[1] = {48'd0, s16, oc[1], ovf[1], oz[1], on[1]};
  assign obs[2] = {s64, oc[2], ovf[2], oz[2], on[2]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact integer arithmetic on w-bit operands.
  // Returns {sum[63:0], C, V, Z, N}.
  function automatic logic [67:0] ref_model(input int w, input logic [1:0] vop,
                                            input logic [63:0] va, input logic [63:0] vb,
                                            input logic vcin);
    logic [67:0]        mask, ua, ub, ce, res, sum;
    logic signed [67:0] lim, sa, sb, sr;
    logic               c, v;
    mask = (68'd1 << w) - 68'd1;
    ua   = {4'd0, va} & mask;
    ub   = {4'd0, vb} & mask;
    ce   = {67'd0, vop[0] ? vcin : 1'b0};
    lim  = 68'sd1 <<< (w - 1);
    sa   = ua[w-1] ? ($signed(ua) - (lim <<< 1)) : $signed(ua);
    sb   = ub[w-1] ? ($signed(ub) - (lim <<< 1)) : $signed(ub);
    if (!vop[1]) begin
      res = ua + ub + ce;
      c   = res[w];
      sr  = sa + sb + $signed(ce);
    end else begin
      res = ua - ub - ce;
      c   = (ua < (ub + ce));
      sr  = sa - sb - $signed(ce);
    end
    sum = res & mask;
    v   = (sr < -lim) || (sr >= lim);
    return {sum[63:0], c, v, (sum == 68'd0), sum[w-1]};
  endfunction

  task automatic test_reset();
    @(negedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({ov[d], obs[d]} !== 69'd0)
        $display("FAIL reset_outputs dut%0d: got valid=%b out=%h want all zero", d, ov[d], obs[d]);
      if ({ov[d], obs[d]} !== 69'd0) errors++;
    end
    checks++;
    if (ir !== 3'b111) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 111", ir);
    end
  endtask

  task automatic test_directed();
    logic [1:0]  t_op  [6] = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b11, 2'b01};
    logic [63:0] t_a   [6] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF,
                               64'd5, 64'd10, 64'h0000_FFFF};
    logic [63:0] t_b   [6] = '{64'd1, 64'd1, 64'd1, 64'd7, 64'd3, 64'd0};
    logic        t_cin [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [67:0] got [3];
    logic [67:0] exp;
    int          lat [3];
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      op = t_op[t]; a = t_a[t]; b = t_b[t]; cin = t_cin[t]; ordy = 1'b1; iv = 3'b111;
      #1;
      checks++;
      if (ir !== 3'b111) begin
        errors++;
        $display("FAIL dir%0d_accept: in_ready=%b want 111", t, ir);
      end
      @(negedge clk);
      iv = 3'b000;
      for (int d = 0; d < 3; d++) begin
        lat[d] = -1;
        got[d] = '0;
      end
      for (int c = 0; c < 10; c++) begin
        #1;
        for (int d = 0; d < 3; d++)
          if (ov[d] === 1'b1 && lat[d] < 0) begin
            lat[d] = c;
            got[d] = obs[d];
          end
        @(negedge clk);
      end
      for (int d = 0; d < 3; d++) begin
        exp = ref_model(w_of[d], t_op[t], t_a[t], t_b[t], t_cin[t]);
        checks++;
        if (lat[d] != lat_of[d] - 1) begin
          errors++;
          $display("FAIL dir%0d_latency dut%0d: got %0d want %0d", t, d, lat[d], lat_of[d] - 1);
        end
        checks++;
        if (got[d] !== exp) begin
          errors++;
          $display("FAIL dir%0d_result dut%0d: got sum=%h cvzn=%b want sum=%h cvzn=%b",
                   t, d, got[d][67:4], got[d][3:0], exp[67:4], exp[3:0]);
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    bit stale;
    @(negedge clk);
    op = 2'b00; a = 64'h1234_5678_9ABC_DEF0; b = 64'h1111_1111_1111_1111; cin = 1'b0;
    ordy = 1'b1; iv = 3'b111;
    @(negedge clk);
    a = 64'h0F0F_0F0F_0F0F_0F0F;
    @(negedge clk);
    iv = 3'b000;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (ov !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid_valid: out_valid=%b want 000", ov);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (ir !== 3'b111) begin
      errors++;
      $display("FAIL reset_mid_ready: in_ready=%b want 111", ir);
    end
    stale = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      if (ov !== 3'b000) stale = 1'b1;
    end
    checks++;
    if (stale) begin
      errors++;
      $display("FAIL reset_mid_stale: a beat emerged after reset, want none");
    end
  endtask

  // Streams nbeats through the 32-bit instance. With rand_ready=0 the sink
  // is always ready, so every beat must land exactly LAT observations later.
  task automatic test_stream(input int nbeats, input bit rand_ready);
    logic [67:0] exp_q [$];
    int          acc_q [$];
    logic [67:0] exp, snap;
    int          sent, got, cyc, acc;
    bit          cur_valid, stalled;
    logic [1:0]  c_op;
    logic [63:0] c_a, c_b;
    logic        c_cin;
    sent = 0; got = 0; cyc = 0; cur_valid = 1'b0; stalled = 1'b0; snap = '0;
    c_op = '0; c_a = '0; c_b = '0; c_cin = 1'b0;
    while (got < nbeats && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (!cur_valid && sent < nbeats && (!rand_ready || $urandom_range(0, 3) != 0)) begin
        cur_valid = 1'b1;
        c_op  = 2'($urandom_range(0, 3));
        c_cin = 1'($urandom_range(0, 1));
        c_a   = {$urandom, $urandom};
        c_b   = {$urandom, $urandom};
        if ($urandom_range(0, 3) == 0) c_a = 64'hFFFF_FFFF;
        if ($urandom_range(0, 5) == 0) c_b = 64'h7FFF_FFFF;
      end
      iv = {2'b00, cur_valid}; op = c_op; a = c_a; b = c_b; cin = c_cin;
      ordy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (stalled) begin
        checks++;
        if (ov[0] !== 1'b1 || obs[0] !== snap) begin
          errors++;
          $display("FAIL stall_hold cyc%0d: valid=%b out=%h want valid=1 out=%h", cyc, ov[0], obs[0], snap);
        end
      end
      if (!rand_ready && cur_valid) begin
        checks++;
        if (ir[0] !== 1'b1) begin
          errors++;
          $display("FAIL b2b_in_ready cyc%0d: got %b want 1", cyc, ir[0]);
        end
      end
      if (ov[0] === 1'b1 && ordy) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stream_extra cyc%0d: unexpected beat %h", cyc, obs[0]);
        end else begin
          exp = exp_q.pop_front();
          acc = acc_q.pop_front();
          got++;
          checks++;
          if (obs[0] !== exp) begin
            errors++;
            $display("FAIL stream_beat%0d: got sum=%h cvzn=%b want sum=%h cvzn=%b",
                     got - 1, obs[0][67:4], obs[0][3:0], exp[67:4], exp[3:0]);
          end
          if (!rand_ready) begin
            checks++;
            if (cyc - acc != lat_of[0]) begin
              errors++;
              $display("FAIL b2b_latency beat%0d: got %0d cycles want %0d", got - 1, cyc - acc, lat_of[0]);
            end
          end
        end
      end
      stalled = (ov[0] === 1'b1) && !ordy;
      snap    = obs[0];
      if (cur_valid && ir[0] === 1'b1) begin
        exp_q.push_back(ref_model(32, c_op, c_a, c_b, c_cin));
        acc_q.push_back(cyc);
        sent++;
        cur_valid = 1'b0;
      end
    end
    iv = 3'b000;
    checks++;
    if (got != nbeats || sent != nbeats) begin
      errors++;
      $display("FAIL stream_count: sent %0d received %0d want %0d", sent, got, nbeats);
    end
    ordy = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (ov[0] !== 1'b0) begin
        errors++;
        $display("FAIL stream_dup: extra beat %h after drain", obs[0]);
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; iv = 3'b000; op = 2'b00; a = '0; b = '0; cin = 1'b0; ordy = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_directed();
    test_reset_midstream();
    test_stream(20, 1'b0);
    test_stream(100, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
